// File: rtl/reg_mask_sequencer_pkg.sv
// Shared register-file definitions: sizes, sequencer state and the
// index-to-decoder-order select mapping (bit reversal of the register index).
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int SEL_W    = 5;

  typedef enum logic {IDLE, SCAN} state_e;

  function automatic logic [SEL_W-1:0] reg_to_sel(input logic [SEL_W-1:0] idx);
    logic [SEL_W-1:0] r;
    for (int i = 0; i < SEL_W; i++) r[i] = idx[SEL_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/reg_mask_sequencer_if.sv
// Request/select handshake bundle for the register-mask sequencer.
// master = control logic side, slave = sequencer side.
interface reg_mask_sequencer_if;
  import regfile_pkg::*;
  logic                req_valid;
  logic                req_ready;
  logic [NUM_REGS-1:0] req_mask;
  logic                sel_valid;
  logic                sel_ready;
  logic [SEL_W-1:0]    sel;
  logic                sel_last;
  logic                done;
  logic                busy;
  logic                abort;

  modport master (
    output req_valid, req_mask, sel_ready, abort,
    input  req_ready, sel_valid, sel, sel_last, done, busy
  );
  modport slave (
    input  req_valid, req_mask, sel_ready, abort,
    output req_ready, sel_valid, sel, sel_last, done, busy
  );
endinterface

// File: rtl/reg_mask_sequencer_enc.sv
// Lowest-set-bit encoder: decoder-order code, one-hot of that bit, any/single flags.
// Purely combinational.
module reg_sel_encoder
  import regfile_pkg::*;
(
  input  logic [NUM_REGS-1:0] vec_i,
  output logic [SEL_W-1:0]    sel_o,
  output logic [NUM_REGS-1:0] onehot_o,
  output logic                any_o,
  output logic                single_o
);
  localparam logic [NUM_REGS-1:0] ONE = 1;

  logic [SEL_W-1:0] idx;

  always_comb begin
    idx = '0;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (vec_i[i]) idx = SEL_W'(i);
    end
    onehot_o = vec_i & (~vec_i + ONE);
    any_o    = |vec_i;
    single_o = any_o && ((vec_i & (vec_i - ONE)) == '0);
    sel_o    = reg_to_sel(idx);
  end
endmodule

// File: rtl/reg_mask_sequencer.sv
// Sequences a 32-bit register mask into decoder-order select codes, lowest register first.
// One code per cycle while sel_ready is high; abort has priority over every handshake.
module reg_mask_sequencer
  import regfile_pkg::*;
#(
  parameter bit SKIP_R0 = 1'b0
) (
  input logic            clock,
  input logic            reset,
  reg_mask_sequencer_if.slave bus
);
  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                done_q, done_d;

  logic [SEL_W-1:0]    enc_sel;
  logic [NUM_REGS-1:0] enc_onehot;
  logic                enc_any;
  logic                enc_single;
  logic [NUM_REGS-1:0] mask_in;

  reg_sel_encoder u_enc (
    .vec_i    (pending_q),
    .sel_o    (enc_sel),
    .onehot_o (enc_onehot),
    .any_o    (enc_any),
    .single_o (enc_single)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    done_d        = 1'b0;
    mask_in       = bus.req_mask;
    if (SKIP_R0) mask_in[0] = 1'b0;

    bus.req_ready = (state_q == IDLE);
    bus.busy      = (state_q == SCAN);
    bus.sel_valid = (state_q == SCAN) && enc_any;
    bus.sel       = '0;
    bus.sel_last  = 1'b0;
    if (state_q == SCAN) begin
      bus.sel      = enc_sel;
      bus.sel_last = enc_single;
    end

    if (bus.abort) begin
      state_d   = IDLE;
      pending_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            pending_d = mask_in;
            if (mask_in != '0) state_d = SCAN;
            else               done_d  = 1'b1;
          end
        end
        SCAN: begin
          if (bus.sel_ready && enc_any) begin
            pending_d = pending_q & ~enc_onehot;
            if (enc_single) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.done = done_q;
endmodule

// File: tb/tb_reg_mask_sequencer.sv
// Directed table-driven bench for reg_mask_sequencer (default and SKIP_R0 instances).
module tb_reg_mask_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  reg_mask_sequencer_if b1 ();
  reg_mask_sequencer_if b2 ();

  reg_mask_sequencer #(.SKIP_R0(1'b0)) dut  (.clock(clock), .reset(reset), .bus(b1.slave));
  reg_mask_sequencer #(.SKIP_R0(1'b1)) dut2 (.clock(clock), .reset(reset), .bus(b2.slave));

  typedef struct {
    logic        rv;
    logic [31:0] mask;
    logic        sr;
    logic        ab;
    logic        sv;
    logic [4:0]  sel;
    logic        last;
    logic        done;
    logic        busy;
    logic        rdy;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl [10];

  function automatic vec_t mk(input logic rv, input logic [31:0] m, input logic sr,
                              input logic ab, input logic sv, input logic [4:0] s,
                              input logic l, input logic d, input logic b, input logic r);
    vec_t v;
    v.rv = rv; v.mask = m; v.sr = sr; v.ab = ab;
    v.sv = sv; v.sel = s; v.last = l; v.done = d; v.busy = b; v.rdy = r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs for the current state, advance a cycle.
  task automatic step(input int which, input vec_t v, input string name);
    logic [9:0] got, exp;
    if (which == 0) begin
      b1.req_valid = v.rv; b1.req_mask = v.mask; b1.sel_ready = v.sr; b1.abort = v.ab;
      got = {b1.sel_valid, b1.sel, b1.sel_last, b1.done, b1.busy, b1.req_ready};
    end else begin
      b2.req_valid = v.rv; b2.req_mask = v.mask; b2.sel_ready = v.sr; b2.abort = v.ab;
      got = {b2.sel_valid, b2.sel, b2.sel_last, b2.done, b2.busy, b2.req_ready};
    end
    exp = {v.sv, v.sel, v.last, v.done, v.busy, v.rdy};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: sv/sel/last/done/busy/rdy got %b expected %b", name, got, exp);
    end
    @(posedge clock); #1;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, " sel_valid"}, 32'(b1.sel_valid), 32'd0);
    chk({name, " sel"},       32'(b1.sel),       32'd0);
    chk({name, " sel_last"},  32'(b1.sel_last),  32'd0);
    chk({name, " done"},      32'(b1.done),      32'd0);
    chk({name, " busy"},      32'(b1.busy),      32'd0);
    chk({name, " req_ready"}, 32'(b1.req_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [4:0] en;
    logic [4:0] exp_sel;
    logic [31:0] dec;

    b1.req_valid = 0; b1.req_mask = '0; b1.sel_ready = 0; b1.abort = 0;
    b2.req_valid = 0; b2.req_mask = '0; b2.sel_ready = 0; b2.abort = 0;

    //        rv  mask          sr ab | sv sel      last done busy rdy
    tbl[0] = mk(1, 32'h0000_0005, 1, 0,  0, 5'b00000, 0, 0, 0, 1);
    tbl[1] = mk(0, 32'h0,         1, 0,  1, 5'b00000, 0, 0, 1, 0);
    tbl[2] = mk(0, 32'h0,         1, 0,  1, 5'b01000, 1, 0, 1, 0);
    tbl[3] = mk(0, 32'h0,         1, 0,  0, 5'b00000, 0, 1, 0, 1);
    tbl[4] = mk(1, 32'h0000_0000, 1, 0,  0, 5'b00000, 0, 0, 0, 1);
    tbl[5] = mk(1, 32'h0000_0008, 1, 0,  0, 5'b00000, 0, 1, 0, 1);
    tbl[6] = mk(0, 32'h0,         0, 0,  1, 5'b11000, 1, 0, 1, 0);
    tbl[7] = mk(0, 32'h0,         1, 0,  1, 5'b11000, 1, 0, 1, 0);
    tbl[8] = mk(0, 32'h0,         1, 0,  0, 5'b00000, 0, 1, 0, 1);
    tbl[9] = mk(0, 32'h0,         1, 0,  0, 5'b00000, 0, 0, 0, 1);

    #2;
    chk_reset_vals("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) step(0, tbl[i], $sformatf("vec%0d", i));

    // All-ones mask with sel_ready toggling: codes stall-stable, in ascending order.
    b1.req_valid = 1; b1.req_mask = 32'hFFFF_FFFF; b1.sel_ready = 0;
    @(posedge clock); #1;
    b1.req_valid = 0;
    n = 0;
    for (int c = 0; c < 80 && n < 32; c++) begin
      en = n[4:0];
      exp_sel = {en[0], en[1], en[2], en[3], en[4]};
      b1.sel_ready = c[0];
      chk($sformatf("ones sel_valid r%0d", n), 32'(b1.sel_valid), 32'd1);
      chk($sformatf("ones sel r%0d", n), 32'(b1.sel), 32'(exp_sel));
      chk($sformatf("ones last r%0d", n), 32'(b1.sel_last), (n == 31) ? 32'd1 : 32'd0);
      dec = 32'd1 << {b1.sel[0], b1.sel[1], b1.sel[2], b1.sel[3], b1.sel[4]};
      chk($sformatf("ones decoder r%0d", n), dec, 32'd1 << n);
      if (n == 16) chk("code reg16", 32'(b1.sel), 32'h01);
      if (n == 1)  chk("code reg1",  32'(b1.sel), 32'h10);
      if (n == 31) chk("code reg31", 32'(b1.sel), 32'h1F);
      if (c[0]) n++;
      @(posedge clock); #1;
    end
    chk("ones handshake count", 32'(n), 32'd32);
    chk("ones done", 32'(b1.done), 32'd1);
    chk("ones idle", 32'(b1.req_ready), 32'd1);
    b1.sel_ready = 0;
    @(posedge clock); #1;

    // Abort while stalled on reg 5, with req_valid held through SCAN.
    step(0, mk(1, 32'h0000_00F0, 1, 0, 0, 5'b00000, 0, 0, 0, 1), "abort accept");
    step(0, mk(1, 32'h0000_0003, 1, 0, 1, 5'b00100, 0, 0, 1, 0), "abort reg4");
    step(0, mk(1, 32'h0000_0003, 0, 1, 1, 5'b10100, 0, 0, 1, 0), "abort reg5 stall");
    step(0, mk(1, 32'h0000_0003, 1, 0, 0, 5'b00000, 0, 0, 0, 1), "abort idle");
    step(0, mk(0, 32'h0,         1, 0, 1, 5'b00000, 0, 0, 1, 0), "post-abort reg0");
    step(0, mk(0, 32'h0,         1, 0, 1, 5'b10000, 1, 0, 1, 0), "post-abort reg1");
    step(0, mk(0, 32'h0,         1, 0, 0, 5'b00000, 0, 1, 0, 1), "post-abort done");
    step(0, mk(0, 32'h0,         1, 0, 0, 5'b00000, 0, 0, 0, 1), "post-abort quiet");

    // SKIP_R0 instance: only reg 1 of mask 0x3.
    step(1, mk(1, 32'h0000_0003, 1, 0, 0, 5'b00000, 0, 0, 0, 1), "skip accept");
    step(1, mk(0, 32'h0,         1, 0, 1, 5'b10000, 1, 0, 1, 0), "skip reg1");
    step(1, mk(0, 32'h0,         1, 0, 0, 5'b00000, 0, 1, 0, 1), "skip done");

    // Reset mid-SCAN drops the mask without a done pulse.
    step(0, mk(1, 32'h8000_0001, 1, 0, 0, 5'b00000, 0, 0, 0, 1), "rst accept");
    step(0, mk(0, 32'h0,         1, 0, 1, 5'b00000, 0, 0, 1, 0), "rst reg0");
    b1.sel_ready = 0;
    chk("rst pre reg31 sel", 32'(b1.sel), 32'h1F);
    chk("rst pre reg31 last", 32'(b1.sel_last), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals("rst async");
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rst release ready", 32'(b1.req_ready), 32'd1);
    @(posedge clock); #1;
    chk("rst no done", 32'(b1.done), 32'd0);
    chk("rst no sel_valid", 32'(b1.sel_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
